// File: rtl/iob_wishbone_master.sv
// iob_wishbone_master
// Bridges the IOb native request bus to a Wishbone B4 classic initiator.
// One transaction is outstanding at a time. It ends on the first of three events:
// a slave ack, a slave err, or an internal timeout.
//
// Ports
//   wb_clk_i, wb_rst_i    clock and synchronous active-high reset
//   iob_avalid_i          request valid (accepted while iob_ready_o=1)
//   iob_addr_i            request byte address
//   iob_wdata_i           write data
//   iob_wstrb_i           byte strobes; nonzero = write, zero = read
//   iob_ready_o           bridge idle, request can be accepted this cycle
//   iob_rvalid_o          one-cycle pulse, iob_rdata_o valid
//   iob_rdata_o           read data, held until the next read completion
//   iob_err_o             one-cycle pulse on err or timeout termination
//   wbm_cyc_o, wbm_stb_o  Wishbone cycle/strobe (always equal)
//   wbm_we_o, wbm_sel_o   write enable and byte select
//   wbm_adr_o, wbm_dat_o  address and write data
//   wbm_dat_i             read data from slave
//   wbm_ack_i, wbm_err_i  slave termination
module iob_wishbone_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,

  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_ready_o,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_err_o,

  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);

  localparam int unsigned SelW = DATA_W / 8;
  // Counter only has to reach TIMEOUT-1; keep at least one bit when timeout is off.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {StIdle, StBus} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [SelW-1:0]     sel_q, sel_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;

  logic timeout_hit;
  logic term_err;
  logic term_any;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
  assign term_err    = wbm_err_i | timeout_hit;
  assign term_any    = term_err | wbm_ack_i;

  // State and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (iob_avalid_i) state_d = StBus;
      StBus:  if (term_any)     state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    we_d     = we_q;
    sel_d    = sel_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    ready_d  = (state_d == StIdle);
    cyc_d    = (state_d == StBus);

    unique case (state_q)
      StIdle: begin
        if (iob_avalid_i) begin
          adr_d = iob_addr_i;
          dat_d = iob_wdata_i;
          cnt_d = '0;
          if (|iob_wstrb_i) begin
            we_d  = 1'b1;
            sel_d = iob_wstrb_i;
          end else begin
            we_d  = 1'b0;
            sel_d = '1;
          end
        end
      end
      StBus: begin
        if (term_err) begin
          // Err wins over a simultaneous ack; a failed read returns zero data.
          err_d = 1'b1;
          if (!we_q) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
          end
        end else if (wbm_ack_i) begin
          if (!we_q) begin
            rvalid_d = 1'b1;
            rdata_d  = wbm_dat_i;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase
  end

  assign iob_ready_o  = ready_q;
  assign iob_rvalid_o = rvalid_q;
  assign iob_err_o    = err_q;
  assign iob_rdata_o  = rdata_q;
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = we_q;
  assign wbm_sel_o    = sel_q;
  assign wbm_adr_o    = adr_q;
  assign wbm_dat_o    = dat_q;

endmodule
